gray_window_3x3: RTL and testbench



---
 rtl/gray_window_3x3_pkg.sv | 23 ++
 rtl/gray_window_3x3_if.sv | 44 ++++
 rtl/gray_window_3x3_line_buffer.sv | 36 +++
 rtl/gray_window_3x3.sv | 135 +++++++++++++
 tb/tb_gray_window_3x3.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/gray_window_3x3_pkg.sv
// ---------------------------------------------------------------------------
// gray_window_3x3_pkg
// Purpose : Constants and types shared by the 3x3 window generator, its line
//           buffer, its interface and the bench.
// Contents: MAX_PIXEL_BITS - default gray pixel width
//           WIN_DIM/WIN_SIZE - window geometry (3x3 = 9 pixels)
//           px_t            - one gray pixel
//           win_idx()       - flat window index k = 3*r + c
// ---------------------------------------------------------------------------
package gray_window_3x3_pkg;

  localparam int MAX_PIXEL_BITS = 8;
  localparam int WIN_DIM        = 3;
  localparam int WIN_SIZE       = WIN_DIM * WIN_DIM;

  typedef logic [MAX_PIXEL_BITS-1:0] px_t;

  // r=0 is the oldest row, c=0 the oldest column, so k=8 is the newest pixel.
  function automatic int win_idx(input int r, input int c);
    return WIN_DIM * r + c;
  endfunction

endpackage

// File: rtl/gray_window_3x3_if.sv
// ---------------------------------------------------------------------------
// gray_window_3x3_if
// Purpose : Pixel-in / window-out signal bundle of the 3x3 window generator.
// Signals : start_i        frame restart (clears position counters)
//           px_rdy_i       in_pixel_i valid this cycle (one strobe per pixel)
//           in_pixel_i     gray pixel in raster order
//           window_o       packed 3x3 window, pixel k at [k*PX_BITS +: PX_BITS]
//           window_valid_o one-cycle pulse, window_o valid
//           frame_done_o   one-cycle pulse after the last pixel of a frame
// Modports: master - pixel source / window consumer side
//           slave  - the window generator itself
// ---------------------------------------------------------------------------
interface gray_window_3x3_if
  import gray_window_3x3_pkg::*;
#(
  parameter int PX_BITS = MAX_PIXEL_BITS
);

  logic                        start_i;
  logic                        px_rdy_i;
  logic [PX_BITS-1:0]          in_pixel_i;
  logic [WIN_SIZE*PX_BITS-1:0] window_o;
  logic                        window_valid_o;
  logic                        frame_done_o;

  modport master (
    output start_i,
    output px_rdy_i,
    output in_pixel_i,
    input  window_o,
    input  window_valid_o,
    input  frame_done_o
  );

  modport slave (
    input  start_i,
    input  px_rdy_i,
    input  in_pixel_i,
    output window_o,
    output window_valid_o,
    output frame_done_o
  );

endinterface

// File: rtl/gray_window_3x3_line_buffer.sv
// ---------------------------------------------------------------------------
// gray_window_3x3_line_buffer
// Purpose : One line of delay for the window generator: a DEPTH-deep,
//           WIDTH-bit shift register that only moves when en_i is high.
//           With DEPTH = image width, dout_o is the pixel directly above the
//           one currently presented on din_i.
// Ports   : clk_i  clock
//           en_i   shift enable (pixel accepted)
//           din_i  pixel entering the line
//           dout_o pixel accepted DEPTH enables ago
// Contents are not reset: stale data is never used in a valid window.
// ---------------------------------------------------------------------------
module gray_window_3x3_line_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      r_sr[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign dout_o = r_sr[DEPTH-1];

endmodule

// File: rtl/gray_window_3x3.sv
// ---------------------------------------------------------------------------
// gray_window_3x3
// Purpose : Sliding 3x3 window generator. Takes a raster-order gray pixel
//           stream, keeps the two previous lines in shift-register line
//           buffers and emits a full 3x3 neighbourhood for every interior
//           pixel; border pixels produce no window, so the output image is
//           (IMG_WIDTH-2) x (IMG_HEIGHT-2).
// Ports   : clk_i    clock, rising edge
//           nreset_i synchronous reset, active low
//           px_if    gray_window_3x3_if.slave (start/pixel in, window out)
// Params  : PX_BITS bits per pixel, IMG_WIDTH / IMG_HEIGHT frame size (>= 3)
// ---------------------------------------------------------------------------
module gray_window_3x3
  import gray_window_3x3_pkg::*;
#(
  parameter int PX_BITS    = MAX_PIXEL_BITS,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  gray_window_3x3_if.slave px_if
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic               r_valid;
  logic               r_done;
  logic [PX_BITS-1:0] r_win [WIN_SIZE];

  logic               w_accept;
  logic               w_col_last;
  logic               w_row_last;
  logic               w_interior;
  logic [PX_BITS-1:0] w_lb0_out;
  logic [PX_BITS-1:0] w_lb1_out;
  logic [PX_BITS-1:0] w_new_col [WIN_DIM];

  // start_i wins over px_rdy_i: a pixel presented with start is dropped.
  assign w_accept   = px_if.px_rdy_i && !px_if.start_i;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_interior = (r_row >= ROW_TWO) && (r_col >= COL_TWO);

  // LB0 delays by one line (row-1), LB1 chains off LB0 for row-2.
  gray_window_3x3_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PX_BITS)
  ) u_lb0 (
    .clk_i  (clk_i),
    .en_i   (w_accept),
    .din_i  (px_if.in_pixel_i),
    .dout_o (w_lb0_out)
  );

  gray_window_3x3_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PX_BITS)
  ) u_lb1 (
    .clk_i  (clk_i),
    .en_i   (w_accept),
    .din_i  (w_lb0_out),
    .dout_o (w_lb1_out)
  );

  // Incoming right-hand column, top (oldest row) to bottom (current row).
  assign w_new_col[0] = w_lb1_out;
  assign w_new_col[1] = w_lb0_out;
  assign w_new_col[2] = px_if.in_pixel_i;

  // Window registers: shift one column left on every accept. start_i does
  // not touch them, so window_o keeps its last value across a restart.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      for (int k = 0; k < WIN_SIZE; k++) begin
        r_win[k] <= '0;
      end
    end else if (w_accept) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM - 1; c++) begin
          r_win[win_idx(r, c)] <= r_win[win_idx(r, c + 1)];
        end
        r_win[win_idx(r, WIN_DIM - 1)] <= w_new_col[r];
      end
    end
  end

  // Position counters and output pulses. Validity is decided from the
  // position of the pixel being accepted, so the pulse lands one cycle later
  // together with the window it completes. Gating on row>=2 also guarantees
  // that line-buffer contents from a previous frame are never exposed.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (px_if.start_i) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_accept && w_interior;
      r_done  <= w_accept && w_row_last && w_col_last;
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIN_SIZE; gi++) begin : g_pack
      assign px_if.window_o[gi*PX_BITS +: PX_BITS] = r_win[gi];
    end
  endgenerate

  assign px_if.window_valid_o = r_valid;
  assign px_if.frame_done_o   = r_done;

endmodule

// File: tb/tb_gray_window_3x3.sv
// ---------------------------------------------------------------------------
// tb_gray_window_3x3
// Bench for gray_window_3x3 on a 4x4 frame. The driver feeds pixels into a
// reference model of the frame; every interior pixel pushes its expected
// window (and frame_done flag) onto a scoreboard queue, which the monitor
// pops whenever the DUT raises window_valid_o.
// ---------------------------------------------------------------------------
module tb_gray_window_3x3;
  import gray_window_3x3_pkg::*;

  localparam int PXB = 8;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int WB  = WIN_SIZE * PXB;

  typedef struct packed {
    logic [WB-1:0] win;
    logic          done;
  } exp_t;

  logic clk;
  logic nreset;

  gray_window_3x3_if #(.PX_BITS(PXB)) px_if ();

  gray_window_3x3 #(
    .PX_BITS    (PXB),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) u_dut (
    .clk_i    (clk),
    .nreset_i (nreset),
    .px_if    (px_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t          sb[$];
  logic [WB-1:0] win_log[$];

  int m_row = 0;
  int m_col = 0;
  int fp[W*H];

  task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WB-1:0] pack9(input int v[9]);
    logic [WB-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*PXB +: PXB] = PXB'(v[k]);
    return w;
  endfunction

  // Reference model: remember the frame, emit the expected window for every
  // interior position directly from the stored pixels.
  task automatic model_accept(input int p);
    exp_t e;
    fp[m_row*W + m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      e.win = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.win[(3*r + c)*PXB +: PXB] = PXB'(fp[(m_row - 2 + r)*W + (m_col - 2 + c)]);
      e.done = (m_row == H-1) && (m_col == W-1);
      sb.push_back(e);
    end
    if (m_col == W-1) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  // Called at posedge+1. Presents one pixel, then idles 'gap' cycles while
  // checking that window_o holds its post-accept value.
  task automatic send_px(input int p, input int gap);
    logic [WB-1:0] held;
    px_if.px_rdy_i   = 1'b1;
    px_if.in_pixel_i = PXB'(p);
    model_accept(p);
    @(posedge clk); #1;
    px_if.px_rdy_i = 1'b0;
    held = px_if.window_o;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check("hold", px_if.window_o, held);
    end
  endtask

  task automatic send_start(input logic with_px, input int p);
    px_if.start_i    = 1'b1;
    px_if.px_rdy_i   = with_px;
    px_if.in_pixel_i = PXB'(p);
    m_row = 0;
    m_col = 0;
    @(posedge clk); #1;
    px_if.start_i  = 1'b0;
    px_if.px_rdy_i = 1'b0;
  endtask

  task automatic run_frame(input int base, input int maxgap);
    for (int i = 0; i < W*H; i++)
      send_px(base + i, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic settle(input string tag, input int nwin);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_sb_empty"}, WB'(sb.size()), WB'(0));
    check({tag, "_nwin"}, WB'(win_log.size()), WB'(nwin));
  endtask

  // Monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (px_if.window_valid_o === 1'b1) begin
      $display("win t=%0t window=%h done=%0b", $time, px_if.window_o, px_if.frame_done_o);
      win_log.push_back(px_if.window_o);
      if (sb.size() == 0) begin
        check("unexpected_win", 1, 0);
      end else begin
        e = sb.pop_front();
        check("win", px_if.window_o, e.win);
        check("done", WB'(px_if.frame_done_o), WB'(e.done));
      end
    end else if (px_if.frame_done_o !== 1'b0) begin
      check("done_without_valid", WB'(px_if.frame_done_o), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [WB-1:0] first_w;
  logic [WB-1:0] last_w;
  logic [WB-1:0] f2_w;

  initial begin
    first_w = pack9('{0, 1, 2, 4, 5, 6, 8, 9, 10});
    last_w  = pack9('{5, 6, 7, 9, 10, 11, 13, 14, 15});
    f2_w    = pack9('{100, 101, 102, 104, 105, 106, 108, 109, 110});

    nreset           = 1'b0;
    px_if.start_i    = 1'b0;
    px_if.px_rdy_i   = 1'b0;
    px_if.in_pixel_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_window", px_if.window_o, '0);
    check("rst_valid", WB'(px_if.window_valid_o), 0);
    check("rst_done", WB'(px_if.frame_done_o), 0);
    nreset = 1'b1;
    @(posedge clk); #1;

    // 1: back-to-back frame
    win_log.delete();
    run_frame(0, 0);
    settle("t1", 4);
    if (win_log.size() == 4) begin
      check("t1_first", win_log[0], first_w);
      check("t1_last", win_log[3], last_w);
    end

    // 2: random idle gaps
    win_log.delete();
    run_frame(0, 5);
    settle("t2", 4);
    if (win_log.size() == 4) begin
      check("t2_first", win_log[0], first_w);
      check("t2_last", win_log[3], last_w);
    end

    // 3: two frames back to back
    win_log.delete();
    run_frame(0, 0);
    run_frame(100, 0);
    settle("t3", 8);
    if (win_log.size() == 8) check("t3_f2_first", win_log[4], f2_w);

    // 4: restart after a partial frame
    win_log.delete();
    for (int i = 0; i < 8; i++) send_px(i, 0);
    send_start(1'b0, 0);
    run_frame(0, 0);
    settle("t4", 4);
    if (win_log.size() == 4) check("t4_first", win_log[0], first_w);

    // 5: start with a pixel in the same cycle drops the pixel
    win_log.delete();
    for (int i = 0; i < 5; i++) send_px(i + 50, 0);
    send_start(1'b1, 99);
    run_frame(0, 0);
    settle("t5", 4);
    if (win_log.size() == 4) begin
      check("t5_first", win_log[0], first_w);
      check("t5_last", win_log[3], last_w);
    end

    // 6: reset mid-frame after pixel 9
    win_log.delete();
    for (int i = 0; i < 10; i++) send_px(i + 20, 1);
    nreset = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    m_row = 0;
    m_col = 0;
    check("t6_rst_window", px_if.window_o, '0);
    check("t6_rst_valid", WB'(px_if.window_valid_o), 0);
    check("t6_rst_done", WB'(px_if.frame_done_o), 0);
    run_frame(0, 0);
    settle("t6", 4);
    if (win_log.size() == 4) begin
      check("t6_first", win_log[0], first_w);
      check("t6_last", win_log[3], last_w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
